mult_div: RTL



---
 rtl/mult_div_pkg.sv | 24 ++
 rtl/div_step.sv | 29 ++
 rtl/mult_div.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// iteration constants and a small magnitude helper.
package mult_div_pkg;

  // Operand width and number of Booth / restoring iterations.
  localparam int unsigned ITER = 32;
  // Width of the iteration counter.
  localparam int unsigned CntW = 6;

  // 3-bit state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t StIdle = 3'd0;
  localparam state_t StMult = 3'd1;
  localparam state_t StDiv  = 3'd2;
  localparam state_t StFix  = 3'd3;
  localparam state_t StDone = 3'd4;

  // Two's-complement magnitude; 0x80000000 maps to itself, which reads
  // correctly as the unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {R,Q} left, trial
// subtract the divisor and restore on a negative result.
module div_step (
  input  logic [32:0] r_i,
  input  logic [31:0] q_i,
  input  logic [31:0] d_i,
  output logic [32:0] r_o,
  output logic [31:0] q_o
);

  logic [32:0] r_sh;
  logic [31:0] q_sh;
  logic [32:0] diff;

  // Trial subtraction; R stays below D (<= 2^31), so the shifted R fits in 33 bits.
  always_comb begin
    r_sh = {r_i[31:0], q_i[31]};
    q_sh = {q_i[30:0], 1'b0};
    diff = r_sh - {1'b0, d_i};
    if (diff[32]) begin
      r_o = r_sh;
      q_o = q_sh;
    end else begin
      r_o = diff;
      q_o = q_sh | 32'd1;
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, magnitude
// based with a sign-fix cycle) producing the HI/LO pair for the MIPS core.
module mult_div #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  import mult_div_pkg::*;

  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [64:0]     p_q, p_d;      // {P_hi, P_lo, q-1}
  logic [31:0]     mcand_q, mcand_d;
  logic [32:0]     r_q, r_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            div_zero_q, div_zero_d;

  logic [32:0]     booth_sum;
  logic [64:0]     p_next;
  logic [32:0]     r_step;
  logic [31:0]     quo_step;
  logic            last_iter;

  div_step u_div_step (
    .r_i (r_q),
    .q_i (quo_q),
    .d_i (dvs_q),
    .r_o (r_step),
    .q_o (quo_step)
  );

  // Booth add/subtract on a 33-bit sign-extended P_hi, then arithmetic shift right.
  always_comb begin
    case (p_q[1:0])
      2'b01:   booth_sum = {p_q[64], p_q[64:33]} + {mcand_q[31], mcand_q};
      2'b10:   booth_sum = {p_q[64], p_q[64:33]} - {mcand_q[31], mcand_q};
      default: booth_sum = {p_q[64], p_q[64:33]};
    endcase
    p_next = {booth_sum, p_q[32:1]};
  end

  assign last_iter = (cnt_q == LastCnt);

  // Next-state and datapath update; HI/LO change only on entry to DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    mcand_d    = mcand_q;
    r_d        = r_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        div_zero_d = 1'b0;
        if (start_mult) begin
          state_d = StMult;
          cnt_d   = '0;
          mcand_d = a_in;
          p_d     = {32'd0, b_in, 1'b0};
        end else if (start_div) begin
          if (b_in == 32'd0) begin
            // Nothing to iterate; report straight away and keep HI/LO.
            state_d    = StDone;
            div_zero_d = 1'b1;
          end else begin
            state_d   = StDiv;
            cnt_d     = '0;
            r_d       = '0;
            quo_d     = abs32(a_in);
            dvs_d     = abs32(b_in);
            neg_quo_d = a_in[31] ^ b_in[31];
            neg_rem_d = a_in[31];
          end
        end
      end
      StMult: begin
        p_d   = p_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
          hi_d    = p_next[64:33];
          lo_d    = p_next[32:1];
        end
      end
      StDiv: begin
        r_d   = r_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Remainder takes the dividend's sign.
        state_d = StDone;
        lo_d    = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        hi_d    = neg_rem_q ? (32'd0 - r_q[31:0]) : r_q[31:0];
      end
      StDone: begin
        state_d    = StIdle;
        div_zero_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      p_q        <= '0;
      mcand_q    <= '0;
      r_q        <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      mcand_q    <= mcand_d;
      r_q        <= r_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign div_zero = div_zero_q;

endmodule
